// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants and types for the MEM stage.
//   - memory / control op codes, ISA exception codes, bus direction
//   - bus-master state encoding
//   - MEM/WB register layout and its NOP value
package mem_stage_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    localparam logic [1:0] MEM_OP_NOP = 2'd0;
    localparam logic [1:0] MEM_OP_LDW = 2'd1;
    localparam logic [1:0] MEM_OP_STW = 2'd2;

    localparam logic [1:0] CTRL_OP_NOP = 2'd0;

    localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
    localparam logic [2:0] ISA_EXP_EXT_INT    = 3'd1;
    localparam logic [2:0] ISA_EXP_UNDEF_INSN = 3'd2;
    localparam logic [2:0] ISA_EXP_OVERFLOW   = 3'd3;
    localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd4;
    localparam logic [2:0] ISA_EXP_BUS_ERR    = 3'd5;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [2:0] {
        BUS_IDLE   = 3'd0,
        BUS_REQ    = 3'd1,
        BUS_ACCESS = 3'd2,
        BUS_WAIT   = 3'd3,
        BUS_DONE   = 3'd4
    } bus_state_e;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] pc;
        logic                   en;
        logic                   br_flag;
        logic [1:0]             ctrl_op;
        logic [4:0]             dst_addr;
        logic                   gpr_we_;
        logic [2:0]             exp_code;
        logic [WORD_DATA_W-1:0] data;
    } memwb_t;

    localparam memwb_t MEMWB_NOP = '{
        pc:       '0,
        en:       1'b0,
        br_flag:  1'b0,
        ctrl_op:  CTRL_OP_NOP,
        dst_addr: 5'd0,
        gpr_we_:  1'b1,
        exp_code: ISA_EXP_NO_EXP,
        data:     '0
    };

endpackage

// File: rtl/mem_bus_if.sv
// mem_bus_if: data-bus master for the MEM stage.
//   in : clk, rst, access (aligned, un-squashed request), kill (squash pending),
//        is_load, addr (word), wr_data, stall, bus_grnt_, bus_rdy_, bus_rd_data
//   out: bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
//        busy (stall request), rd_data (load result), bus_err (time-out result)
module mem_bus_if
    import mem_stage_pkg::*;
#(
    parameter int RDY_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   access,
    input  logic                   kill,
    input  logic                   is_load,
    input  logic                   stall,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic [WORD_DATA_W-1:0] wr_data,
    input  logic                   bus_grnt_,
    input  logic                   bus_rdy_,
    input  logic [WORD_DATA_W-1:0] bus_rd_data,
    output logic                   bus_req_,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic [WORD_DATA_W-1:0] bus_wr_data,
    output logic                   busy,
    output logic [WORD_DATA_W-1:0] rd_data,
    output logic                   bus_err
);

    bus_state_e             state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [WORD_DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic                   err_q, err_d;
    logic                   rdy, timeout;

    assign rdy     = ~bus_rdy_;
    // Counter holds k in the k-th WAIT cycle, so the limit hits in cycle RDY_TIMEOUT.
    assign timeout = (cnt_q == 8'(RDY_TIMEOUT));

    always_comb begin
        state_d     = state_q;
        cnt_d       = 8'd0;
        rd_buf_d    = rd_buf_q;
        err_d       = err_q;
        bus_req_    = 1'b1;
        bus_as_     = 1'b1;
        bus_rw      = READ;
        bus_addr    = '0;
        bus_wr_data = '0;
        busy        = 1'b0;
        rd_data     = bus_rd_data;
        bus_err     = 1'b0;
        case (state_q)
            BUS_IDLE: begin
                // A squashed access neither starts a bus cycle nor holds the pipe.
                if (access && !kill) begin
                    busy    = 1'b1;
                    state_d = BUS_REQ;
                end
            end
            BUS_REQ: begin
                busy     = 1'b1;
                bus_req_ = 1'b0;
                if (kill)            state_d = BUS_IDLE;
                else if (!bus_grnt_) state_d = BUS_ACCESS;
            end
            BUS_ACCESS: begin
                busy        = 1'b1;
                bus_req_    = 1'b0;
                bus_as_     = 1'b0;
                bus_rw      = is_load ? READ : WRITE;
                bus_addr    = addr;
                bus_wr_data = wr_data;
                cnt_d       = 8'd1;
                state_d     = BUS_WAIT;
            end
            BUS_WAIT: begin
                // Address/data stay on the bus until the slave answers.
                bus_req_    = 1'b0;
                bus_rw      = is_load ? READ : WRITE;
                bus_addr    = addr;
                bus_wr_data = wr_data;
                if (rdy || timeout) begin
                    if (rdy) rd_buf_d = bus_rd_data;
                    err_d   = !rdy;
                    bus_err = !rdy;
                    state_d = stall ? BUS_DONE : BUS_IDLE;
                end else begin
                    busy  = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            BUS_DONE: begin
                // Result parked while the pipe is stalled elsewhere.
                rd_data = rd_buf_q;
                bus_err = err_q;
                if (!stall) state_d = BUS_IDLE;
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BUS_IDLE;
            cnt_q    <= 8'd0;
            rd_buf_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_buf_q <= rd_buf_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Consumes EX/MEM (ex_*), runs loads/stores on
// the data bus through mem_bus_if and produces the MEM/WB register (mem_*).
//   in : clk, reset, stall, flush, ex_* fields, bus_grnt_, bus_rdy_, bus_rd_data
//   out: bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data, busy, mem_* fields
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int RDY_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [WORD_ADDR_W-1:0] ex_pc,
    input  logic                   ex_en,
    input  logic                   ex_br_flag,
    input  logic [1:0]             ex_mem_op,
    input  logic [WORD_DATA_W-1:0] ex_mem_wr_data,
    input  logic [1:0]             ex_ctrl_op,
    input  logic [4:0]             ex_dst_addr,
    input  logic                   ex_gpr_we_,
    input  logic [2:0]             ex_exp_code,
    input  logic [WORD_DATA_W-1:0] ex_out,
    input  logic                   bus_grnt_,
    input  logic                   bus_rdy_,
    input  logic [WORD_DATA_W-1:0] bus_rd_data,
    output logic                   bus_req_,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic [WORD_DATA_W-1:0] bus_wr_data,
    output logic                   busy,
    output logic [WORD_ADDR_W-1:0] mem_pc,
    output logic                   mem_en,
    output logic                   mem_br_flag,
    output logic [1:0]             mem_ctrl_op,
    output logic [4:0]             mem_dst_addr,
    output logic                   mem_gpr_we_,
    output logic [2:0]             mem_exp_code,
    output logic [WORD_DATA_W-1:0] mem_out
);

    logic                   mem_req, access, misalign, kill, is_load;
    logic                   discard_q, discard_d;
    logic [WORD_DATA_W-1:0] rd_data;
    logic                   bus_err;
    memwb_t                 memwb_q, memwb_d;

    assign is_load  = (ex_mem_op == MEM_OP_LDW);
    assign mem_req  = ex_en && (ex_mem_op != MEM_OP_NOP) && (ex_exp_code == ISA_EXP_NO_EXP);
    assign access   = mem_req && (ex_out[1:0] == 2'b00);
    assign misalign = mem_req && (ex_out[1:0] != 2'b00);
    // A flush seen while stalled is remembered until the register can take it.
    assign kill     = flush || discard_q;

    mem_bus_if #(.RDY_TIMEOUT(RDY_TIMEOUT)) u_bus_if (
        .clk         (clk),
        .rst         (reset),
        .access      (access),
        .kill        (kill),
        .is_load     (is_load),
        .stall       (stall),
        .addr        (ex_out[WORD_DATA_W-1:2]),
        .wr_data     (ex_mem_wr_data),
        .bus_grnt_   (bus_grnt_),
        .bus_rdy_    (bus_rdy_),
        .bus_rd_data (bus_rd_data),
        .bus_req_    (bus_req_),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .busy        (busy),
        .rd_data     (rd_data),
        .bus_err     (bus_err)
    );

    always_comb begin
        discard_d = stall && kill;
        memwb_d   = memwb_q;
        if (!stall) begin
            if (kill) begin
                memwb_d = MEMWB_NOP;
            end else begin
                memwb_d.pc       = ex_pc;
                memwb_d.en       = ex_en;
                memwb_d.br_flag  = ex_br_flag;
                memwb_d.ctrl_op  = ex_ctrl_op;
                memwb_d.dst_addr = ex_dst_addr;
                memwb_d.gpr_we_  = ex_gpr_we_;
                memwb_d.exp_code = ex_exp_code;
                memwb_d.data     = is_load ? rd_data : ex_out;
                if (misalign) begin
                    memwb_d.exp_code = ISA_EXP_MISS_ALIGN;
                    memwb_d.gpr_we_  = 1'b1;
                    memwb_d.ctrl_op  = CTRL_OP_NOP;
                end else if (bus_err) begin
                    memwb_d.exp_code = ISA_EXP_BUS_ERR;
                    memwb_d.gpr_we_  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memwb_q   <= MEMWB_NOP;
            discard_q <= 1'b0;
        end else begin
            memwb_q   <= memwb_d;
            discard_q <= discard_d;
        end
    end

    assign mem_pc       = memwb_q.pc;
    assign mem_en       = memwb_q.en;
    assign mem_br_flag  = memwb_q.br_flag;
    assign mem_ctrl_op  = memwb_q.ctrl_op;
    assign mem_dst_addr = memwb_q.dst_addr;
    assign mem_gpr_we_  = memwb_q.gpr_we_;
    assign mem_exp_code = memwb_q.exp_code;
    assign mem_out      = memwb_q.data;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage (time-out limit set to 4).
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, ext_stall, flush;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag, ex_gpr_we_;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wr_data, ex_out, bus_rd_data, bus_wr_data, mem_out;
    logic [4:0]  ex_dst_addr, mem_dst_addr;
    logic [2:0]  ex_exp_code, mem_exp_code;
    logic        bus_grnt_, bus_rdy_, bus_req_, bus_as_, bus_rw, busy;
    logic [29:0] bus_addr, mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    // The controller's stall includes busy.
    assign stall = busy | ext_stall;

    mem_stage #(.RDY_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
        .bus_grnt_(bus_grnt_), .bus_rdy_(bus_rdy_), .bus_rd_data(bus_rd_data),
        .bus_req_(bus_req_), .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .busy(busy),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
        .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
        .mem_out(mem_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] dst, input logic we_);
        ex_en = 1'b1; ex_pc = 30'h123; ex_br_flag = 1'b0; ex_mem_op = op;
        ex_mem_wr_data = wd; ex_ctrl_op = 2'd0; ex_dst_addr = dst; ex_gpr_we_ = we_;
        ex_exp_code = ISA_EXP_NO_EXP; ex_out = addr;
    endtask

    task automatic ex_clr();
        ex_en = 1'b0; ex_pc = '0; ex_br_flag = 1'b0; ex_mem_op = MEM_OP_NOP;
        ex_mem_wr_data = '0; ex_ctrl_op = 2'd0; ex_dst_addr = '0; ex_gpr_we_ = 1'b1;
        ex_exp_code = ISA_EXP_NO_EXP; ex_out = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ext_stall = 1'b0; flush = 1'b0; ex_clr();
        bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = '0;
        #3;
        chk("rst_req", bus_req_, 1); chk("rst_as", bus_as_, 1); chk("rst_rw", bus_rw, 1);
        chk("rst_addr", bus_addr, 0); chk("rst_wd", bus_wr_data, 0); chk("rst_busy", busy, 0);
        chk("rst_en", mem_en, 0); chk("rst_we", mem_gpr_we_, 1);
        chk("rst_exp", mem_exp_code, 0); chk("rst_out", mem_out, 0);
        tick(); reset = 1'b0;

        // 1: aligned load, grant and ready immediate
        set_ex(MEM_OP_LDW, 32'h100, 32'h0, 5'd3, 1'b0); bus_rd_data = 32'hDEADBEEF;
        #1 chk("t1_idle_busy", busy, 1); chk("t1_idle_req", bus_req_, 1);
        tick(); chk("t1_req_req", bus_req_, 0); chk("t1_req_busy", busy, 1); chk("t1_req_as", bus_as_, 1);
        tick(); chk("t1_acc_as", bus_as_, 0); chk("t1_acc_addr", bus_addr, 32'h40);
        chk("t1_acc_rw", bus_rw, 1); chk("t1_acc_busy", busy, 1);
        tick(); chk("t1_wait_busy", busy, 0); chk("t1_wait_as", bus_as_, 1); chk("t1_wait_req", bus_req_, 0);
        tick(); ex_clr(); #1;
        chk("t1_out", mem_out, 32'hDEADBEEF); chk("t1_en", mem_en, 1);
        chk("t1_dst", mem_dst_addr, 3); chk("t1_we", mem_gpr_we_, 0); chk("t1_req_end", bus_req_, 1);

        // 2: store with grant delayed 3 cycles
        tick(); set_ex(MEM_OP_STW, 32'h204, 32'h12345678, 5'd0, 1'b1); bus_grnt_ = 1'b1;
        #1 chk("t2_idle_busy", busy, 1);
        tick(); chk("t2_req1", bus_req_, 0); chk("t2_req1_busy", busy, 1);
        tick(); chk("t2_req2_busy", busy, 1); chk("t2_req2_as", bus_as_, 1);
        tick(); bus_grnt_ = 1'b0; #1 chk("t2_req3_busy", busy, 1);
        tick(); chk("t2_acc_as", bus_as_, 0); chk("t2_acc_rw", bus_rw, 0);
        chk("t2_acc_wd", bus_wr_data, 32'h12345678); chk("t2_acc_addr", bus_addr, 32'h81);
        tick(); chk("t2_wait_busy", busy, 0);
        tick(); ex_clr(); #1;
        chk("t2_en", mem_en, 1); chk("t2_we", mem_gpr_we_, 1); chk("t2_out", mem_out, 32'h204);

        // 3: misaligned load
        tick(); set_ex(MEM_OP_LDW, 32'h102, 32'h0, 5'd7, 1'b0); ex_ctrl_op = 2'd2;
        #1 chk("t3_busy", busy, 0); chk("t3_req", bus_req_, 1);
        tick(); ex_clr(); #1;
        chk("t3_exp", mem_exp_code, ISA_EXP_MISS_ALIGN); chk("t3_we", mem_gpr_we_, 1);
        chk("t3_ctrl", mem_ctrl_op, CTRL_OP_NOP); chk("t3_en", mem_en, 1); chk("t3_req_end", bus_req_, 1);

        // 4: ready never comes, limit 4
        tick(); set_ex(MEM_OP_LDW, 32'h10, 32'h0, 5'd1, 1'b0); bus_rdy_ = 1'b1;
        tick(); tick();
        tick(); chk("t4_w1_busy", busy, 1);
        tick(); chk("t4_w2_busy", busy, 1);
        tick(); chk("t4_w3_busy", busy, 1);
        tick(); chk("t4_w4_busy", busy, 0); chk("t4_w4_req", bus_req_, 0);
        tick(); ex_clr(); bus_rdy_ = 1'b0; #1;
        chk("t4_exp", mem_exp_code, ISA_EXP_BUS_ERR); chk("t4_we", mem_gpr_we_, 1); chk("t4_req", bus_req_, 1);

        // 5: ready under external stall, result parked in DONE
        tick(); set_ex(MEM_OP_LDW, 32'h300, 32'h0, 5'd9, 1'b0); bus_rd_data = 32'hA5A50001;
        tick(); tick();
        tick(); ext_stall = 1'b1; #1 chk("t5_wait_busy", busy, 0);
        tick(); bus_rd_data = 32'hBAD0BAD0; #1;
        chk("t5_done_busy", busy, 0); chk("t5_done_req", bus_req_, 1); chk("t5_hold_en", mem_en, 0);
        tick(); ext_stall = 1'b0;
        tick(); ex_clr(); #1;
        chk("t5_out", mem_out, 32'hA5A50001); chk("t5_en", mem_en, 1); chk("t5_dst", mem_dst_addr, 9);
        tick(); chk("t5_no_req", bus_req_, 1); chk("t5_no_busy", busy, 0);

        // 6a: flush in REQ
        set_ex(MEM_OP_LDW, 32'h400, 32'h0, 5'd2, 1'b0); bus_grnt_ = 1'b1;
        tick(); flush = 1'b1; #1 chk("t6a_req_busy", busy, 1); chk("t6a_req_req", bus_req_, 0);
        tick(); flush = 1'b0; #1;
        chk("t6a_as", bus_as_, 1); chk("t6a_req", bus_req_, 1); chk("t6a_busy", busy, 0);
        tick(); ex_clr(); bus_grnt_ = 1'b0; #1 chk("t6a_en", mem_en, 0);

        // 6b: flush in WAIT completes the bus cycle, result discarded
        tick(); set_ex(MEM_OP_LDW, 32'h500, 32'h0, 5'd4, 1'b0); bus_rd_data = 32'h11112222; bus_rdy_ = 1'b1;
        tick();
        tick(); chk("t6b_as", bus_as_, 0);
        tick(); flush = 1'b1;
        tick(); flush = 1'b0; bus_rdy_ = 1'b0; #1;
        chk("t6b_w2_req", bus_req_, 0); chk("t6b_w2_busy", busy, 0);
        tick(); ex_clr(); #1 chk("t6b_en", mem_en, 0); chk("t6b_req", bus_req_, 1);

        // 6c: reset in WAIT releases the bus at once
        tick(); set_ex(MEM_OP_LDW, 32'h600, 32'h0, 5'd5, 1'b0); bus_rdy_ = 1'b1;
        tick(); tick(); tick(); chk("t6c_wait_req", bus_req_, 0);
        reset = 1'b1; #1 chk("t6c_req", bus_req_, 1); chk("t6c_as", bus_as_, 1);
        ex_clr(); bus_rdy_ = 1'b0;
        tick(); reset = 1'b0;
        tick(); chk("t6c_busy", busy, 0); chk("t6c_en", mem_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
